hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS32 core. It watches the IF/ID, ID/EX, EX/MEM and MEM/WB instruction registers and produces `Stall`, `Flush`, `PC_en`, the sticky `HALTED` flag and the EX-stage forwarding selects. It sits beside `id_stage` and drives that stage's `Stall` and `HALTED` inputs. It also owns the halt-drain state machine.

## Interface
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN before `HALTED` asserts. Minimum 3.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset. Synchronous, active-high.
- `IF_ID_IR` in 32: instruction in decode.
- `ID_EX_IR`, `ID_EX_TYPE` in 32/3: instruction and type in EX.
- `EX_MEM_IR`, `EX_MEM_TYPE` in 32/3: instruction and type in MEM.
- `MEM_WB_IR`, `MEM_WB_TYPE` in 32/3: instruction and type in WB.
- `EX_MEM_br_taken` in 1: branch now in EX/MEM resolved taken.
- `Stall` out 1: hold PC and IF/ID, inject a bubble (TYPE=HALT, IR=0) into ID/EX.
- `Flush` out 1: squash IF/ID and ID/EX; PC loads the branch target.
- `PC_en` out 1: PC update enable.
- `HALTED` out 1: sticky halt, cleared only by `rst`.
- `FwdA`, `FwdB` out 2: EX operand A/B source. 00 = ID/EX, 01 = EX/MEM ALU result, 10 = MEM/WB result, 11 = last-retired result.

## Operation
- **Type codes:** RR = 000, RM = 001, LOAD = 010, STORE = 011, BRANCH = 100, HALT = 101.
- **Bubbles:** a bubble has TYPE = HALT and IR = 0. Halt is therefore detected only by opcode `IR[31:26] = 6'b111111`, never by TYPE.
- **Destination register:**
  - RR writes `IR[15:11]`.
  - RM and LOAD write `IR[20:16]`.
  - All other types write nothing.
  - A destination of r0 never counts as a hazard.
- **Source registers:**
  - rs = `IR[25:21]` for RR, RM, LOAD, STORE and BRANCH.
  - rt = `IR[20:16]` for RR and STORE only.
- **State machine:** three states, RUN, DRAIN and HALTED_S.
  - **RUN:** `PC_en = !Stall`.
    - If `IF_ID_IR` is HLT, `Flush = 0` and `Stall = 0`, go to DRAIN and load `cnt = DRAIN_CYCLES`.
  - **DRAIN:** `Stall = 1`, `PC_en = 0`, `cnt` decrements each cycle.
    - When `cnt = 1`, go to HALTED_S.
    - If `EX_MEM_br_taken` asserts, assert `Flush`, clear `cnt`, return to RUN. The HLT was in the branch shadow.
  - **HALTED_S:** `HALTED = 1`, `Stall = 1`, `PC_en = 0`. Exits only on `rst`.
- **Flush:** `Flush = EX_MEM_br_taken` while in RUN or DRAIN.
  - Flush overrides Stall: `Stall` is forced to 0 and `PC_en` to 1.
  - An HLT and a branch in the same cycle: branch wins, no drain.
- **Last-retired register:** captures the MEM_WB destination (or 0) every cycle. It covers the case where ID read the register file on the same edge as the WB write.
- **Forwarding:** computed for ID/EX rs and rt against the EX/MEM destination (RR/RM only), the MEM/WB destination and the last-retired destination.
  - Priority is 01 > 10 > 11.
  - Source r0 always selects 00.

## Timing
- `Stall`, `Flush`, `PC_en` and `Fwd*` are combinational from the inputs and the registered state.
- `HALTED` is registered.
- **During `rst`:** `Stall = 0`, `Flush = 1`, `PC_en = 0`, `Fwd* = 00`, `HALTED = 0`.
- **After `rst`:** state = RUN, `cnt = 0`, last-retired register = 0.
- **rst mid-DRAIN or in HALTED_S:** returns to RUN on the next edge.
- **Load-use stall (FWD_EN):** exactly 1 cycle.
- **RAW stall without forwarding:** 3, 2 or 1 cycles, for a producer in ID/EX, EX/MEM or MEM/WB respectively.
- **HLT to HALTED:** HLT decoded in cycle t gives `HALTED = 1` from cycle t + `DRAIN_CYCLES` + 1.

## Configuration
- **`HAZARD_FWD_EN` defined:**
  - Forwarding is active.
  - `Stall` asserts only for load-use: `ID_EX_TYPE = LOAD` and its destination matches an IF/ID source.
- **`HAZARD_FWD_EN` undefined:**
  - `FwdA` and `FwdB` are tied to 00.
  - `Stall` asserts while any IF/ID source matches the destination in ID/EX, EX/MEM or MEM/WB.
  - The last-retired register is removed.

## Test plan
- **Load-use:** `LW r2,0(r1)` followed by `ADD r3,r2,r4`, with FWD_EN → `Stall = 1` for one cycle, then `FwdA = 10` when the ADD reaches EX.
- **Back-to-back ALU:** `ADD r5,r1,r2` followed by `SUB r6,r5,r5`, with FWD_EN → no stall, `FwdA = FwdB = 01`. Without FWD_EN → `Stall` for 3 cycles, `Fwd* = 00`.
- **Taken branch while a load-use stall is pending:** `EX_MEM_br_taken = 1` → `Flush = 1`, `Stall = 0`, `PC_en = 1` in the same cycle.
- **HLT drain:** HLT in IF/ID at cycle 10 → DRAIN for cycles 11–13, `HALTED = 1` from cycle 14, `PC_en = 0` throughout.
- **HLT in branch shadow:** `EX_MEM_br_taken` asserts in cycle 12 of DRAIN → `Flush = 1`, state returns to RUN, `HALTED` stays 0.
- **Reset out of halt:** `rst` pulse while in HALTED_S → `HALTED = 0` and RUN on the next cycle. A write to r0 never triggers a stall or a forward.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard, forwarding and halt-drain controller for the 5-stage MIPS32 core.
// Optional macro HAZARD_FWD_EN enables EX-stage forwarding and limits stalls to load-use.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_id_ir_i,
    input  logic [31:0] id_ex_ir_i,
    input  logic [2:0]  id_ex_type_i,
    input  logic [31:0] ex_mem_ir_i,
    input  logic [2:0]  ex_mem_type_i,
    input  logic [31:0] mem_wb_ir_i,
    input  logic [2:0]  mem_wb_type_i,
    input  logic        ex_mem_br_taken_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        pc_en_o,
    output logic        halted_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o
);
    localparam logic [2:0] TYPE_RR     = 3'b000;
    localparam logic [2:0] TYPE_RM     = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_STORE  = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_HALT   = 3'b101;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED_S} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q;

    logic [2:0] ifType;
    logic [4:0] ifRs, ifRt, idExRs, idExRt;
    logic [4:0] idExDst, exMemDst, memWbDst;
    logic       ifIsHalt, rawHazard;
    logic [1:0] fwdA, fwdB;
    logic       unusedInputs;

    function automatic logic [4:0] dstOf(input logic [31:0] ir, input logic [2:0] typ);
        case (typ)
            TYPE_RR:              dstOf = ir[15:11];
            TYPE_RM, TYPE_LOAD:   dstOf = ir[20:16];
            default:              dstOf = 5'd0;
        endcase
    endfunction

    function automatic logic usesRs(input logic [2:0] typ);
        return (typ == TYPE_RR) || (typ == TYPE_RM) || (typ == TYPE_LOAD) ||
               (typ == TYPE_STORE) || (typ == TYPE_BRANCH);
    endfunction

    function automatic logic usesRt(input logic [2:0] typ);
        return (typ == TYPE_RR) || (typ == TYPE_STORE);
    endfunction

    // IF/ID carries no type field, so its class is recovered from the opcode.
    function automatic logic [2:0] decodeType(input logic [5:0] op);
        if (op == 6'b000000)          return TYPE_RR;
        else if (op[5:3] == 3'b001)   return TYPE_RM;
        else if (op == 6'b100011)     return TYPE_LOAD;
        else if (op == 6'b101011)     return TYPE_STORE;
        else if (op[5:1] == 5'b00010) return TYPE_BRANCH;
        else                          return TYPE_HALT;
    endfunction

    function automatic logic readsDst(input logic [4:0] dst, input logic [4:0] rs,
                                      input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

    always_comb begin
        ifType   = decodeType(if_id_ir_i[31:26]);
        ifIsHalt = (if_id_ir_i[31:26] == 6'b111111);
        ifRs     = usesRs(ifType) ? if_id_ir_i[25:21] : 5'd0;
        ifRt     = usesRt(ifType) ? if_id_ir_i[20:16] : 5'd0;
        idExRs   = usesRs(id_ex_type_i) ? id_ex_ir_i[25:21] : 5'd0;
        idExRt   = usesRt(id_ex_type_i) ? id_ex_ir_i[20:16] : 5'd0;
        idExDst  = dstOf(id_ex_ir_i, id_ex_type_i);
        exMemDst = dstOf(ex_mem_ir_i, ex_mem_type_i);
        memWbDst = dstOf(mem_wb_ir_i, mem_wb_type_i);
    end

`ifdef HAZARD_FWD_EN
    logic [4:0] lastDst_q;
    logic [4:0] exMemFwdDst;

    // Covers a WB write landing on the same edge that ID read the register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) lastDst_q <= 5'd0;
        else       lastDst_q <= memWbDst;
    end

    function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic [4:0] exMem,
                                          input logic [4:0] memWb, input logic [4:0] last);
        if (src == 5'd0)        return 2'b00;
        else if (src == exMem)  return 2'b01;
        else if (src == memWb)  return 2'b10;
        else if (src == last)   return 2'b11;
        else                    return 2'b00;
    endfunction

    always_comb begin
        exMemFwdDst = ((ex_mem_type_i == TYPE_RR) || (ex_mem_type_i == TYPE_RM)) ? exMemDst : 5'd0;
        fwdA        = fwdSel(idExRs, exMemFwdDst, memWbDst, lastDst_q);
        fwdB        = fwdSel(idExRt, exMemFwdDst, memWbDst, lastDst_q);
        rawHazard   = (id_ex_type_i == TYPE_LOAD) && readsDst(idExDst, ifRs, ifRt);
    end
`else
    always_comb begin
        fwdA      = 2'b00;
        fwdB      = 2'b00;
        rawHazard = readsDst(idExDst, ifRs, ifRt) || readsDst(exMemDst, ifRs, ifRt) ||
                    readsDst(memWbDst, ifRs, ifRt);
    end
`endif

    assign unusedInputs = ^{if_id_ir_i, id_ex_ir_i, ex_mem_ir_i, mem_wb_ir_i, idExRs, idExRt};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALTED_S);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!ex_mem_br_taken_i && ifIsHalt) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (ex_mem_br_taken_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = HALTED_S;
                end
            end
            HALTED_S: state_d = HALTED_S;
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // A taken branch always wins over stalls and a pending halt.
    always_comb begin
        stall_o  = 1'b0;
        flush_o  = 1'b0;
        pc_en_o  = 1'b0;
        halted_o = 1'b0;
        fwd_a_o  = 2'b00;
        fwd_b_o  = 2'b00;
        if (rst_i) begin
            flush_o = 1'b1;
        end else begin
            halted_o = halted_q;
            fwd_a_o  = fwdA;
            fwd_b_o  = fwdB;
            case (state_q)
                RUN: begin
                    flush_o = ex_mem_br_taken_i;
                    if (ex_mem_br_taken_i || ifIsHalt) begin
                        pc_en_o = 1'b1;
                    end else begin
                        stall_o = rawHazard;
                        pc_en_o = !rawHazard;
                    end
                end
                DRAIN: begin
                    flush_o = ex_mem_br_taken_i;
                    stall_o = !ex_mem_br_taken_i;
                    pc_en_o = ex_mem_br_taken_i;
                end
                HALTED_S: stall_o = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
